// File: rtl/occupancy_detector.sv
// occupancy_detector
//   Turns the asynchronous raw presence sensor into a registered room-occupied
//   level for the RGB status LED stage. The sensor is synchronised (2 FFs),
//   debounced, and occupancy is held for HOLD_CYCLES after the last detection.
//   One-cycle entry/exit pulses are produced for logging.
// Ports
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset
//   presenca_raw   : raw sensor (async), 1 = presence
//   forcar_livre   : 1 = force room free (maintenance override)
//   ocupado        : registered occupied level
//   presenca_db    : registered debounced sensor level
//   evento_entrada : one-cycle pulse on ocupado 0->1
//   evento_saida   : one-cycle pulse on ocupado 1->0
//   hold_restante  : remaining hold cycles while timing out, else 0
module occupancy_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 1000,
  localparam int unsigned HOLD_W         = $clog2(HOLD_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              presenca_raw,
  input  logic              forcar_livre,
  output logic              ocupado,
  output logic              presenca_db,
  output logic              evento_entrada,
  output logic              evento_saida,
  output logic [HOLD_W-1:0] hold_restante
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    LIVRE        = 2'd0,
    OCUPADO      = 2'd1,
    TEMPORIZANDO = 2'd2
  } state_t;

  logic              sync1_q, sync2_q;
  logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic              db_q, db_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ocupado_q, ocupado_d;
  logic              entrada_q, entrada_d;
  logic              saida_q, saida_d;

  // Debounce: any cycle where the synchronised input agrees with the current
  // debounced level restarts the count; the last differing cycle toggles.
  always_comb begin
    db_cnt_d = '0;
    db_d     = db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // FSM next state plus registered outputs. Events are derived from the
  // state transition so they coincide with the ocupado edge.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    if (forcar_livre) begin
      state_d = LIVRE;
    end else begin
      unique case (state_q)
        LIVRE: begin
          if (db_q) state_d = OCUPADO;
        end
        OCUPADO: begin
          if (!db_q) begin
            state_d = TEMPORIZANDO;
            hold_d  = HOLD_LOAD;
          end
        end
        TEMPORIZANDO: begin
          if (db_q) begin
            state_d = OCUPADO;
          end else if (hold_q == '0) begin
            state_d = LIVRE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: state_d = LIVRE;
      endcase
    end
    ocupado_d = (state_d != LIVRE);
    entrada_d = (state_q == LIVRE) && (state_d == OCUPADO);
    saida_d   = (state_q != LIVRE) && (state_d == LIVRE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      db_q      <= 1'b0;
      state_q   <= LIVRE;
      hold_q    <= '0;
      ocupado_q <= 1'b0;
      entrada_q <= 1'b0;
      saida_q   <= 1'b0;
    end else begin
      sync1_q   <= presenca_raw;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      db_q      <= db_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      ocupado_q <= ocupado_d;
      entrada_q <= entrada_d;
      saida_q   <= saida_d;
    end
  end

  assign ocupado        = ocupado_q;
  assign presenca_db    = db_q;
  assign evento_entrada = entrada_q;
  assign evento_saida   = saida_q;
  assign hold_restante  = hold_q;

endmodule
